multi_digit_led_driver: RTL

Parametrised time-multiplexed seven-segment driver, successor to the fixed four-digit driver. Scans `NUM_DIGITS` common-anode digits from a packed hex word, with per-digit decimal-point and blanking masks, an anti-ghosting guard interval between digits, and a shadow register so updates never tear mid-frame. Sits between the receiver's data path and the board's anode and segment pins.

---
 rtl/led_display_pkg.sv | 30 +++
 rtl/multi_digit_led_driver_if.sv | 25 ++
 rtl/led_hex_decoder.sv | 32 +++
 rtl/multi_digit_led_driver.sv | 167 ++++++++++++++++
 4 files changed

// File: rtl/led_display_pkg.sv
// Shared constants for the multiplexed seven-segment driver: FSM encoding and
// active-low segment patterns in {a,b,c,d,e,f,g} order.
package led_display_pkg;

  typedef logic [1:0] state_t;

  localparam state_t StIdle  = 2'd0;
  localparam state_t StGuard = 2'd1;
  localparam state_t StShow  = 2'd2;

  localparam logic [6:0] Seg0 = 7'h01;
  localparam logic [6:0] Seg1 = 7'h4F;
  localparam logic [6:0] Seg2 = 7'h12;
  localparam logic [6:0] Seg3 = 7'h06;
  localparam logic [6:0] Seg4 = 7'h4C;
  localparam logic [6:0] Seg5 = 7'h24;
  localparam logic [6:0] Seg6 = 7'h20;
  localparam logic [6:0] Seg7 = 7'h0F;
  localparam logic [6:0] Seg8 = 7'h00;
  localparam logic [6:0] Seg9 = 7'h04;
  localparam logic [6:0] SegA = 7'h08;
  localparam logic [6:0] SegB = 7'h60;
  localparam logic [6:0] SegC = 7'h31;
  localparam logic [6:0] SegD = 7'h42;
  localparam logic [6:0] SegE = 7'h30;
  localparam logic [6:0] SegF = 7'h38;

  localparam logic [6:0] SEG_BLANK = 7'h7F;

endpackage

// File: rtl/multi_digit_led_driver_if.sv
// Data-path and pin bundle of the LED driver. The master side supplies display
// data and masks; the slave side (the driver) produces anode/segment pins.
interface multi_digit_led_driver_if #(
  parameter int unsigned NUM_DIGITS = 4
);
  logic                      enable;
  logic [4*NUM_DIGITS-1:0]   signal_to_display;
  logic                      update;
  logic [NUM_DIGITS-1:0]     dp_mask;
  logic [NUM_DIGITS-1:0]     blank_mask;
  logic [NUM_DIGITS-1:0]     an;
  logic [6:0]                seg;
  logic                      dp;
  logic                      frame_done;

  modport master (
    output enable, signal_to_display, update, dp_mask, blank_mask,
    input  an, seg, dp, frame_done
  );

  modport slave (
    input  enable, signal_to_display, update, dp_mask, blank_mask,
    output an, seg, dp, frame_done
  );
endinterface

// File: rtl/led_hex_decoder.sv
// Combinational hex nibble to active-low seven-segment pattern.
module led_hex_decoder
  import led_display_pkg::*;
(
  input  logic [3:0] nibble_i,
  output logic [6:0] seg_o
);

  always_comb begin
    seg_o = SEG_BLANK;
    case (nibble_i)
      4'h0: seg_o = Seg0;
      4'h1: seg_o = Seg1;
      4'h2: seg_o = Seg2;
      4'h3: seg_o = Seg3;
      4'h4: seg_o = Seg4;
      4'h5: seg_o = Seg5;
      4'h6: seg_o = Seg6;
      4'h7: seg_o = Seg7;
      4'h8: seg_o = Seg8;
      4'h9: seg_o = Seg9;
      4'hA: seg_o = SegA;
      4'hB: seg_o = SegB;
      4'hC: seg_o = SegC;
      4'hD: seg_o = SegD;
      4'hE: seg_o = SegE;
      4'hF: seg_o = SegF;
      default: seg_o = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/multi_digit_led_driver.sv
// Time-multiplexed common-anode driver: descending digit scan with a dark guard
// at each slot start, and a pending/shadow pair so data only changes at frame wrap.
module multi_digit_led_driver
  import led_display_pkg::*;
#(
  parameter int unsigned NUM_DIGITS   = 4,
  parameter int unsigned DWELL_CYCLES = 16,
  parameter int unsigned BLANK_CYCLES = 2
) (
  input logic                      clk,
  input logic                      reset,
  multi_digit_led_driver_if.slave  bus
);

  localparam int unsigned IdxW  = (NUM_DIGITS > 2) ? $clog2(NUM_DIGITS) : 1;
  localparam int unsigned DwW   = (DWELL_CYCLES > 2) ? $clog2(DWELL_CYCLES) : 1;
  localparam int unsigned DataW = 4 * NUM_DIGITS;

  localparam logic [IdxW-1:0] IdxTop    = IdxW'(NUM_DIGITS - 1);
  localparam logic [DwW-1:0]  DwLast    = DwW'(DWELL_CYCLES - 1);
  localparam logic [DwW-1:0]  GuardLast = DwW'((BLANK_CYCLES > 0) ? BLANK_CYCLES - 1 : 0);
  // With no guard every slot starts straight in SHOW.
  localparam state_t          SlotStart = (BLANK_CYCLES > 0) ? StGuard : StShow;

  state_t            state_q, state_d;
  logic [IdxW-1:0]   idx_q, idx_d;
  logic [DwW-1:0]    dwell_q, dwell_d;
  logic [DataW-1:0]  shadow_q, shadow_d;
  logic [DataW-1:0]  pending_q, pending_d;
  logic              pending_valid_q, pending_valid_d;
  logic [NUM_DIGITS-1:0] an_q, an_d;
  logic [6:0]        seg_q, seg_d;
  logic              dp_q, dp_d;
  logic              frame_done_q, frame_done_d;

  logic              wrap;
  logic [3:0]        nibble;
  logic [6:0]        seg_dec;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    dwell_d = dwell_q;
    wrap    = 1'b0;
    if (!bus.enable) begin
      state_d = StIdle;
      idx_d   = IdxTop;
      dwell_d = '0;
    end else begin
      case (state_q)
        StIdle: begin
          state_d = SlotStart;
          idx_d   = IdxTop;
          dwell_d = '0;
        end
        StGuard: begin
          dwell_d = dwell_q + DwW'(1);
          if (dwell_q == GuardLast) begin
            state_d = StShow;
          end
        end
        StShow: begin
          if (dwell_q == DwLast) begin
            dwell_d = '0;
            state_d = SlotStart;
            if (idx_q == '0) begin
              idx_d = IdxTop;
              wrap  = 1'b1;
            end else begin
              idx_d = idx_q - IdxW'(1);
            end
          end else begin
            dwell_d = dwell_q + DwW'(1);
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  // A strobe on the wrap edge supersedes whatever was pending.
  always_comb begin
    shadow_d        = shadow_q;
    pending_d       = pending_q;
    pending_valid_d = pending_valid_q;
    if (state_q == StIdle) begin
      if (bus.update) begin
        shadow_d = bus.signal_to_display;
      end
    end else if (wrap) begin
      if (bus.update) begin
        shadow_d = bus.signal_to_display;
      end else if (pending_valid_q) begin
        shadow_d = pending_q;
      end
      pending_valid_d = 1'b0;
    end else if (bus.update) begin
      pending_d       = bus.signal_to_display;
      pending_valid_d = 1'b1;
    end
  end

  // Decode from next-state values so pins change on the edge entering a slot.
  always_comb begin
    nibble = '0;
    for (int i = 0; i < int'(NUM_DIGITS); i++) begin
      if (idx_d == IdxW'(i)) begin
        nibble = shadow_d[4*i +: 4];
      end
    end
  end

  led_hex_decoder u_dec (
    .nibble_i (nibble),
    .seg_o    (seg_dec)
  );

  always_comb begin
    an_d         = '1;
    seg_d        = SEG_BLANK;
    dp_d         = 1'b1;
    frame_done_d = wrap;
    if (state_d != StIdle) begin
      seg_d = seg_dec;
    end
    if (state_d == StShow) begin
      for (int i = 0; i < int'(NUM_DIGITS); i++) begin
        if (idx_d == IdxW'(i)) begin
          an_d[i] = bus.blank_mask[i];
          dp_d    = ~bus.dp_mask[i];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q         <= StIdle;
      idx_q           <= IdxTop;
      dwell_q         <= '0;
      shadow_q        <= '0;
      pending_q       <= '0;
      pending_valid_q <= 1'b0;
      an_q            <= '1;
      seg_q           <= SEG_BLANK;
      dp_q            <= 1'b1;
      frame_done_q    <= 1'b0;
    end else begin
      state_q         <= state_d;
      idx_q           <= idx_d;
      dwell_q         <= dwell_d;
      shadow_q        <= shadow_d;
      pending_q       <= pending_d;
      pending_valid_q <= pending_valid_d;
      an_q            <= an_d;
      seg_q           <= seg_d;
      dp_q            <= dp_d;
      frame_done_q    <= frame_done_d;
    end
  end

  assign bus.an         = an_q;
  assign bus.seg        = seg_q;
  assign bus.dp         = dp_q;
  assign bus.frame_done = frame_done_q;

endmodule
